// File: rtl/axis_circular_pkg.sv
// Shared definitions for the circular-buffer capture/readout path.
// Holds the readout FSM states, FIFO sizing and the modulo-depth address helper.
package axis_circular_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } unroll_state_e;

    localparam int FIFO_DEPTH = 2;

    // (a - b) mod 2^addr_width; callers truncate the result to their address width.
    function automatic logic [31:0] circ_sub(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned addr_width);
        logic [31:0] mask;
        mask = (32'd1 << addr_width) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/axis_circular_unroller_fifo.sv
// Two-entry register FIFO carrying {tuser?, tlast, tdata} between the BRAM read
// port and the stream output; count feeds the read-issue credit check.
module axis_circular_unroller_fifo
    import axis_circular_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    // With exactly two entries the pointers are single bits that toggle.
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(wr_en) - 2'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign valid   = (count != 2'd0);

endmodule

// File: rtl/axis_circular_unroller.sv
// Reads the circular capture BRAM back in chronological order as one AXI4-Stream
// packet. Optional tuser trigger marker enabled by AXIS_CIRCULAR_UNROLLER_TUSER_EN.
module axis_circular_unroller
    import axis_circular_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        start,
    input  logic [CNTR_WIDTH-1:0]       trigger_pos,
    input  logic [CNTR_WIDTH-1:0]       cfg_pretrig,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    output logic                        busy,
    output logic                        done,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    output logic                        bram_porta_en,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
`ifdef AXIS_CIRCULAR_UNROLLER_TUSER_EN
    ,
    output logic                        m_axis_tuser
`endif
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam logic [CNTR_WIDTH-1:0] DEPTH_C = CNTR_WIDTH'(1) << AW;
`ifdef AXIS_CIRCULAR_UNROLLER_TUSER_EN
    localparam int FW = AXIS_TDATA_WIDTH + 2;
`else
    localparam int FW = AXIS_TDATA_WIDTH + 1;
`endif

    unroll_state_e state_q, state_d;

    logic [AW-1:0] addr_q;
    logic [AW:0]   remaining_q;
    logic          rd_pending_q;
    logic          rd_last_q;
    logic          zero_done_q;
    logic [AW:0]   len_clipped;
    logic          start_ok;
    logic          issue;
    logic          issue_last;
    logic          pop;
    logic          last_hs;
    logic [2:0]    reserved;

    logic [FW-1:0] fifo_wr_data;
    logic [FW-1:0] fifo_out;
    logic          fifo_valid;
    logic [1:0]    fifo_count;

`ifdef AXIS_CIRCULAR_UNROLLER_TUSER_EN
    logic [AW-1:0] trig_addr_q;
    logic          rd_user_q;
`endif

    // Lengths beyond one full buffer are clipped to the buffer depth.
    always_comb begin
        len_clipped = cfg_length[AW:0];
        if (cfg_length >= DEPTH_C) begin
            len_clipped = {1'b1, {AW{1'b0}}};
        end
    end

    // reserved counts FIFO slots already spoken for, including the read in flight.
    assign reserved   = {1'b0, fifo_count} + {2'b00, rd_pending_q};
    assign pop        = fifo_valid & m_axis_tready;
    assign start_ok   = (state_q == IDLE) && start;
    assign issue      = (state_q == RUN) && (remaining_q != '0)
                        && ((reserved - {2'b00, pop}) < 3'd2);
    assign issue_last = issue && (remaining_q == (AW+1)'(1));
    assign last_hs    = pop & fifo_out[AXIS_TDATA_WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (cfg_length != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_last_q    <= 1'b0;
            zero_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= issue;
            rd_last_q    <= issue_last;
            zero_done_q  <= start_ok && (cfg_length == '0);
            if (start_ok) begin
                addr_q      <= AW'(circ_sub(32'(trigger_pos), 32'(cfg_pretrig), AW));
                remaining_q <= len_clipped;
            end else if (issue) begin
                addr_q      <= addr_q + AW'(1);
                remaining_q <= remaining_q - (AW+1)'(1);
            end
        end
    end

`ifdef AXIS_CIRCULAR_UNROLLER_TUSER_EN
    // The trigger sample is recognised by address, so it is flagged only if read.
    always_ff @(posedge aclk) begin
        if (areset) begin
            trig_addr_q <= '0;
            rd_user_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                trig_addr_q <= AW'(trigger_pos);
            end
            rd_user_q <= issue && (addr_q == trig_addr_q);
        end
    end

    assign fifo_wr_data = {rd_user_q, rd_last_q, bram_porta_rddata};
    assign m_axis_tuser = fifo_valid & fifo_out[AXIS_TDATA_WIDTH+1];
`else
    assign fifo_wr_data = {rd_last_q, bram_porta_rddata};
`endif

    axis_circular_unroller_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (aclk),
        .flush   (areset),
        .wr_en   (rd_pending_q),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_out),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign busy            = (state_q != IDLE);
    assign done            = last_hs | zero_done_q;
    assign bram_porta_en   = issue;
    assign bram_porta_addr = addr_q;
    assign m_axis_tvalid   = fifo_valid;
    assign m_axis_tdata    = fifo_out[AXIS_TDATA_WIDTH-1:0];
    assign m_axis_tlast    = fifo_valid & fifo_out[AXIS_TDATA_WIDTH];

endmodule
